// File: rtl/seg8_scan_display.sv
// Tear-free 8-digit multiplexed 7-segment hex display driver.
// A captured value is staged in a pending register and becomes visible only at a frame boundary.
module seg8_scan_display #(
    parameter int unsigned REFRESH_DIV = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [31:0] i_data,
    input  logic        blank_lz,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        o_pending,
    output logic        o_frame
);

    function automatic logic [7:0] enc(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [REFRESH_DIV-1:0] presc_q, presc_d;
    logic [2:0]             digit_q, digit_d;
    logic [31:0]            disp_q, disp_d;
    logic [31:0]            pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [7:0]             seg_q, seg_d;
    logic [7:0]             sel_q, sel_d;
    logic                   frame_q, frame_d;

    logic       tick;
    logic       frame_bnd;
    logic [3:0] nibble;
    logic [7:0] zero_from;   // zero_from[k]: nibbles k..7 of disp are all zero

    always_comb begin
        tick      = &presc_q;
        frame_bnd = tick && (digit_q == 3'd7);

        presc_d = presc_q + 1'b1;
        digit_d = tick ? digit_q + 3'd1 : digit_q;

        // Commit reads the old pend before a same-cycle strobe replaces it,
        // so a strobe on the boundary keeps pend_valid set for the next frame.
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (frame_bnd && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
        if (cs) begin
            pend_d       = i_data;
            pend_valid_d = 1'b1;
        end

        zero_from[7] = (disp_q[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (disp_q[4*k +: 4] == 4'h0);
        end

        nibble  = disp_q[{digit_q, 2'b00} +: 4];
        sel_d   = ~(8'b0000_0001 << digit_q);
        seg_d   = enc(nibble);
        if (blank_lz && (digit_q != 3'd0) && zero_from[digit_q]) begin
            seg_d = 8'hFF;
        end
        frame_d = frame_bnd;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset returns the pins to all-off immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            digit_q      <= 3'd0;
            disp_q       <= 32'h0;
            pend_q       <= 32'h0;
            pend_valid_q <= 1'b0;
            seg_q        <= 8'hFF;
            sel_q        <= 8'hFF;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_q      <= frame_d;
        end
    end

    assign o_seg     = seg_q;
    assign o_sel     = sel_q;
    assign o_pending = pend_valid_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg8_scan_display.sv
// Self-checking bench for seg8_scan_display at REFRESH_DIV=2 (tick every 4 cycles, frame 32 cycles).
// A cycle-count based reference model checks every cycle; table vectors check whole frames.
module tb_seg8_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [31:0] i_data;
    logic        blank_lz;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        o_pending;
    logic        o_frame;

    int checks = 0;
    int errors = 0;

    seg8_scan_display #(.REFRESH_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .i_data    (i_data),
        .blank_lz  (blank_lz),
        .o_seg     (o_seg),
        .o_sel     (o_sel),
        .o_pending (o_pending),
        .o_frame   (o_frame)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: m_t counts rising edges since reset release.
    int          m_t;
    logic [31:0] m_disp, m_pend;
    logic        m_pv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [31:0] v, input int d, input logic bl);
        logic [31:0] upper;
        upper = v >> (4 * d);
        if (bl && d != 0 && upper == 32'h0) return 8'hFF;
        return seg_lut[upper[3:0]];
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_disp = 32'h0;
        m_pend = 32'h0;
        m_pv   = 1'b0;
    endtask

    // Inputs are already driven; advance one clock and compare all outputs.
    task automatic cyc();
        int         d;
        bit         bnd;
        logic [7:0] e_seg, e_sel;
        logic       e_frame;
        d       = (m_t / 4) % 8;
        bnd     = (m_t % 32) == 31;
        e_sel   = 8'hFF ^ (8'h01 << d);
        e_seg   = ref_seg(m_disp, d, blank_lz);
        e_frame = bnd;
        if (bnd && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (cs) begin
            m_pend = i_data;
            m_pv   = 1'b1;
        end
        m_t++;
        @(negedge clk);
        check($sformatf("sel t=%0d", m_t), {24'h0, o_sel}, {24'h0, e_sel});
        check($sformatf("seg t=%0d", m_t), {24'h0, o_seg}, {24'h0, e_seg});
        check($sformatf("frame t=%0d", m_t), {31'h0, o_frame}, {31'h0, e_frame});
        check($sformatf("pending t=%0d", m_t), {31'h0, o_pending}, {31'h0, m_pv});
    endtask

    task automatic align(input int phase);
        while ((m_t % 32) != phase) cyc();
    endtask

    task automatic write(input logic [31:0] v);
        cs     = 1'b1;
        i_data = v;
        cyc();
        cs     = 1'b0;
    endtask

    // Entry at a frame start; exp holds the segment byte of digit k in exp[8k+:8].
    task automatic capture_frame(input string name, input logic [63:0] exp);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc();
                if (j == 0) begin
                    check($sformatf("%s sel%0d", name, k), {24'h0, o_sel}, {24'h0, 8'hFF ^ (8'h01 << k)});
                    check($sformatf("%s seg%0d", name, k), {24'h0, o_seg}, {24'h0, exp[8*k +: 8]});
                end
            end
        end
    endtask

    typedef struct {
        bit          pre_en;
        logic [31:0] pre;
        logic [31:0] data;
        logic        blank;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b0, 32'h0, 32'h0040_00A4, 1'b1, 64'hFFFF_99C0_C0C0_8899};
        vecs[1] = '{1'b1, 32'h1234_5678, 32'h89AB_CDEF, 1'b0, 64'h8090_8883_C6A1_868E};
        vecs[2] = '{1'b0, 32'h0, 32'h1234_5678, 1'b0, 64'hF9A4_B099_9282_F880};
        vecs[3] = '{1'b0, 32'h0, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[4] = '{1'b0, 32'h0, 32'h0000_0000, 1'b0, 64'hC0C0_C0C0_C0C0_C0C0};
        vecs[5] = '{1'b0, 32'h0, 32'h0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0};

        reset    = 1'b1;
        cs       = 1'b0;
        i_data   = 32'h0;
        blank_lz = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset seg", {24'h0, o_seg}, 32'h0000_00FF);
        check("reset sel", {24'h0, o_sel}, 32'h0000_00FF);
        check("reset pending", {31'h0, o_pending}, 32'h0);
        check("reset frame", {31'h0, o_frame}, 32'h0);
        reset = 1'b0;

        // Idle scan after reset: first edge selects digit 0 showing 0.
        cyc();
        check("first sel", {24'h0, o_sel}, 32'h0000_00FE);
        check("first seg", {24'h0, o_seg}, 32'h0000_00C0);
        repeat (39) cyc();

        // Frame-level vectors: write, wait for commit, inspect the next frame.
        foreach (vecs[i]) begin
            blank_lz = vecs[i].blank;
            align(4);
            if (vecs[i].pre_en) write(vecs[i].pre);
            write(vecs[i].data);
            check($sformatf("vec%0d pending", i), {31'h0, o_pending}, 32'h1);
            align(0);
            check($sformatf("vec%0d committed", i), {31'h0, o_pending}, 32'h0);
            capture_frame($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Toggling blank_lz off while zero is shown takes effect on the next digit.
        align(12);
        check("lz before toggle", {24'h0, o_seg}, 32'h0000_00FF);
        blank_lz = 1'b0;
        cyc();
        check("lz after toggle", {24'h0, o_seg}, 32'h0000_00C0);

        // Strobe exactly on the boundary while pend holds 1.
        blank_lz = 1'b1;
        align(4);
        write(32'h1);
        align(31);
        write(32'hFFFF_FFFF);
        check("bnd frame", {31'h0, o_frame}, 32'h1);
        check("bnd pending kept", {31'h0, o_pending}, 32'h1);
        capture_frame("bnd old", 64'hFFFF_FFFF_FFFF_FFF9);
        check("bnd pending cleared", {31'h0, o_pending}, 32'h0);
        capture_frame("bnd new", 64'h8E8E_8E8E_8E8E_8E8E);

        // Reset mid-frame at digit 4 with a pending value.
        blank_lz = 1'b0;
        align(4);
        write(32'h5555_5555);
        align(17);
        reset = 1'b1;
        #1;
        check("midrst seg", {24'h0, o_seg}, 32'h0000_00FF);
        check("midrst sel", {24'h0, o_sel}, 32'h0000_00FF);
        check("midrst pending", {31'h0, o_pending}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        capture_frame("post rst 0", 64'hC0C0_C0C0_C0C0_C0C0);
        capture_frame("post rst 1", 64'hC0C0_C0C0_C0C0_C0C0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) begin
                cs     = 1'b1;
                i_data = $urandom >> (4 * $urandom_range(8));
            end else begin
                cs = 1'b0;
            end
            if ($urandom_range(63) == 0) blank_lz = ~blank_lz;
            cyc();
        end
        cs = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
